// File: rtl/fetch_stage.sv
// ==== fetch_stage : in-order fetch buffer feeding the instruction FIFO ====
// ==== redirect squashes buffered work and drains stale responses -- rev 1.0 ====
`default_nettype none

module fetch_stage #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 32,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             redirect_valid,
  input  logic [ADDR_WIDTH-1:0]            redirect_pc,
  output logic                             imem_req_valid,
  output logic [ADDR_WIDTH-1:0]            imem_req_addr,
  input  logic                             imem_req_ready,
  input  logic                             imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]            imem_rsp_data,
  output logic                             fifo_wr_en,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_wr_data,
  input  logic                             fifo_wr_valid,
  input  logic                             fifo_almost_full,
  output logic [ADDR_WIDTH-1:0]            fetch_pc,
  output logic                             draining
);

  localparam int             PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int             CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]  LAST_IDX = PW'(MAX_OUTSTANDING - 1);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [CW-1:0]              drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0]      fetch_pc_q;
  logic [ADDR_WIDTH-1:0]      pc_q   [MAX_OUTSTANDING];
  logic [INST_WIDTH-1:0]      inst_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] filled_q;
  logic [PW-1:0]              alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CW-1:0]              occ_q, unfilled_q;

  logic          req_fire, rsp_fill, pop;
  logic [CW-1:0] drop_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fill = imem_rsp_valid && (state_q == S_FETCH) && !redirect_valid && (unfilled_q != '0);
  assign pop      = fifo_wr_en && fifo_wr_valid;
  assign drop_sum = drop_cnt_q + unfilled_q;

  assign imem_req_addr = fetch_pc_q;
  assign fetch_pc      = fetch_pc_q;
  assign fifo_wr_en    = !reset && !redirect_valid && filled_q[head_ptr_q];
  assign fifo_wr_data  = reset ? '0 : {pc_q[head_ptr_q], inst_q[head_ptr_q]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // A response arriving with the redirect is itself one of the stale ones.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      if (!imem_rsp_valid)
        drop_cnt_d = drop_sum;
      else if (drop_sum != '0)
        drop_cnt_d = drop_sum - CW'(1);
      else
        drop_cnt_d = '0;
      state_d = (drop_cnt_d != '0) ? S_DRAIN : S_FETCH;
    end else if ((state_q == S_DRAIN) && imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
      if (drop_cnt_d == '0)
        state_d = S_FETCH;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    draining       = 1'b0;
    if (!reset) begin
      draining       = (state_q == S_DRAIN);
      imem_req_valid = (state_q == S_FETCH) && !redirect_valid &&
                       (occ_q < MAX_CNT) && !fifo_almost_full;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      unfilled_q  <= '0;
      filled_q    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q  <= redirect_pc;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      unfilled_q  <= '0;
      filled_q    <= '0;
    end else begin
      if (req_fire) begin
        pc_q[alloc_ptr_q] <= fetch_pc_q;
        alloc_ptr_q       <= ptr_inc(alloc_ptr_q);
        fetch_pc_q        <= fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (rsp_fill) begin
        inst_q[fill_ptr_q]   <= imem_rsp_data;
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= ptr_inc(fill_ptr_q);
      end
      // Head is filled and the fill slot is not, so these never collide.
      if (pop) begin
        filled_q[head_ptr_q] <= 1'b0;
        head_ptr_q           <= ptr_inc(head_ptr_q);
      end
      occ_q      <= occ_q + CW'(req_fire) - CW'(pop);
      unfilled_q <= unfilled_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && imem_rsp_valid && (state_q == S_FETCH) && !redirect_valid)
      assert (unfilled_q != '0);
  end

endmodule

`default_nettype wire
